// File: rtl/gerenciador_de_ataque_param.sv
// gerenciador_de_ataque_param: clocked attack manager for the LED-matrix naval battle.
// Tracks shots, reveals hits, counts misses and resolves win/lose.
`default_nettype none

module gerenciador_de_ataque_param #(
  parameter  int NUM_COLUNAS = 5,
  parameter  int NUM_LINHAS  = 7,
  parameter  int LARG_COORD  = 3,
  parameter  int MAX_ERROS   = 10,
  localparam int N           = NUM_COLUNAS * NUM_LINHAS,
  localparam int LARG_CONT   = $clog2(N + 1),
  localparam int LARG_ERROS  = $clog2(MAX_ERROS + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  confirmar,
  input  logic [LARG_COORD-1:0] coordColuna,
  input  logic [LARG_COORD-1:0] coordLinha,
  input  logic [N-1:0]          mapa,
  output logic [N-1:0]          matriz,
  output logic [N-1:0]          tiros,
  output logic [LARG_CONT-1:0]  acertos,
  output logic [LARG_ERROS-1:0] errosRestantes,
  output logic                  acerto,
  output logic                  erro,
  output logic                  repetido,
  output logic                  invalido,
  output logic                  vitoria,
  output logic                  derrota
);

  typedef enum logic [1:0] {OCIOSO, JOGANDO, VITORIA, DERROTA} estado_t;

  estado_t               estado_q, estado_d;
  logic [N-1:0]          matriz_q, matriz_d;
  logic [N-1:0]          tiros_q, tiros_d;
  logic [LARG_CONT-1:0]  acertos_q, acertos_d;
  logic [LARG_ERROS-1:0] erros_q, erros_d;
  logic                  acerto_q, acerto_d;
  logic                  erro_q, erro_d;
  logic                  repetido_q, repetido_d;
  logic                  invalido_q, invalido_d;
  logic                  conf_ant_q, conf_ant_d;

  logic                  press;
  logic                  coord_ok;
  logic [31:0]           idx;
  logic [N-1:0]          mascara;
  logic [LARG_CONT-1:0]  total;

  assign press    = confirmar & ~conf_ant_q;
  assign coord_ok = (32'(coordColuna) < 32'(NUM_COLUNAS)) && (32'(coordLinha) < 32'(NUM_LINHAS));
  assign idx      = 32'(coordColuna) * 32'(NUM_LINHAS) + 32'(coordLinha);
  // One-hot cell select; stays zero for out-of-range coordinates so nothing is ever indexed.
  assign mascara  = coord_ok ? (N'(1) << idx) : '0;

  always_comb begin
    total = '0;
    for (int i = 0; i < N; i++) begin
      total = total + LARG_CONT'(mapa[i]);
    end
  end

  always_comb begin
    estado_d   = estado_q;
    matriz_d   = matriz_q;
    tiros_d    = tiros_q;
    acertos_d  = acertos_q;
    erros_d    = erros_q;
    acerto_d   = 1'b0;
    erro_d     = 1'b0;
    repetido_d = 1'b0;
    invalido_d = 1'b0;
    conf_ant_d = confirmar;

    if (!enable) begin
      estado_d   = OCIOSO;
      matriz_d   = '0;
      tiros_d    = '0;
      acertos_d  = '0;
      erros_d    = LARG_ERROS'(MAX_ERROS);
      conf_ant_d = 1'b0;
    end else begin
      case (estado_q)
        OCIOSO: estado_d = JOGANDO;
        JOGANDO: begin
          if (total == '0) begin
            estado_d = VITORIA;
          end else if (press) begin
            if (!coord_ok) begin
              invalido_d = 1'b1;
            end else if (|(tiros_q & mascara)) begin
              repetido_d = 1'b1;
            end else if (|(mapa & mascara)) begin
              tiros_d   = tiros_q | mascara;
              matriz_d  = matriz_q | mascara;
              acertos_d = acertos_q + LARG_CONT'(1);
              acerto_d  = 1'b1;
              if (acertos_q + LARG_CONT'(1) == total) estado_d = VITORIA;
            end else begin
              tiros_d = tiros_q | mascara;
              erros_d = erros_q - LARG_ERROS'(1);
              erro_d  = 1'b1;
              // Last miss reveals the whole fleet on the same edge.
              if (erros_q == LARG_ERROS'(1)) begin
                estado_d = DERROTA;
                matriz_d = mapa;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q   <= OCIOSO;
      matriz_q   <= '0;
      tiros_q    <= '0;
      acertos_q  <= '0;
      erros_q    <= LARG_ERROS'(MAX_ERROS);
      acerto_q   <= 1'b0;
      erro_q     <= 1'b0;
      repetido_q <= 1'b0;
      invalido_q <= 1'b0;
      conf_ant_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      matriz_q   <= matriz_d;
      tiros_q    <= tiros_d;
      acertos_q  <= acertos_d;
      erros_q    <= erros_d;
      acerto_q   <= acerto_d;
      erro_q     <= erro_d;
      repetido_q <= repetido_d;
      invalido_q <= invalido_d;
      conf_ant_q <= conf_ant_d;
    end
  end

  assign matriz         = matriz_q;
  assign tiros          = tiros_q;
  assign acertos        = acertos_q;
  assign errosRestantes = erros_q;
  assign acerto         = acerto_q;
  assign erro           = erro_q;
  assign repetido       = repetido_q;
  assign invalido       = invalido_q;
  assign vitoria        = (estado_q == VITORIA);
  assign derrota        = (estado_q == DERROTA);

endmodule

`default_nettype wire

// File: tb/tb_gerenciador_de_ataque_param.sv
// Testbench for gerenciador_de_ataque_param: two instances (MAX_ERROS=3 and 10),
// per-press expected pulses queued at drive time and popped when the result appears.
`default_nettype none

module tb_gerenciador_de_ataque_param;

  localparam logic [34:0] MAPA_TESTE = 35'h7_0000_1071; // bits 0,4,5,6,12,32,33,34

  logic        clock = 1'b0;
  logic        reset, enable, confirmar;
  logic [2:0]  coordColuna, coordLinha;
  logic [34:0] mapa;

  logic [34:0] matriz3, tiros3, matriz10, tiros10;
  logic [5:0]  acertos3, acertos10;
  logic [1:0]  erros3;
  logic [3:0]  erros10;
  logic        ac3, er3, rp3, iv3, vit3, der3;
  logic        ac10, er10, rp10, iv10, vit10, der10;

  gerenciador_de_ataque_param #(.NUM_COLUNAS(5), .NUM_LINHAS(7), .LARG_COORD(3), .MAX_ERROS(3)) u_dut3 (
    .clock(clock), .reset(reset), .enable(enable), .confirmar(confirmar),
    .coordColuna(coordColuna), .coordLinha(coordLinha), .mapa(mapa),
    .matriz(matriz3), .tiros(tiros3), .acertos(acertos3), .errosRestantes(erros3),
    .acerto(ac3), .erro(er3), .repetido(rp3), .invalido(iv3), .vitoria(vit3), .derrota(der3));

  gerenciador_de_ataque_param #(.NUM_COLUNAS(5), .NUM_LINHAS(7), .LARG_COORD(3), .MAX_ERROS(10)) u_dut10 (
    .clock(clock), .reset(reset), .enable(enable), .confirmar(confirmar),
    .coordColuna(coordColuna), .coordLinha(coordLinha), .mapa(mapa),
    .matriz(matriz10), .tiros(tiros10), .acertos(acertos10), .errosRestantes(erros10),
    .acerto(ac10), .erro(er10), .repetido(rp10), .invalido(iv10), .vitoria(vit10), .derrota(der10));

  always #5 clock = ~clock;

  // Observed outputs of whichever instance the current test targets.
  logic        sel10;
  logic [34:0] o_matriz, o_tiros;
  logic [5:0]  o_acertos;
  logic [3:0]  o_erros, o_pulsos;
  logic        o_vit, o_der;

  always_comb begin
    if (sel10) begin
      o_matriz = matriz10; o_tiros = tiros10; o_acertos = acertos10; o_erros = erros10;
      o_pulsos = {ac10, er10, rp10, iv10}; o_vit = vit10; o_der = der10;
    end else begin
      o_matriz = matriz3; o_tiros = tiros3; o_acertos = acertos3; o_erros = {2'b00, erros3};
      o_pulsos = {ac3, er3, rp3, iv3}; o_vit = vit3; o_der = der3;
    end
  end

  int checks = 0;
  int failures = 0;

  // Reference model
  int          m_max, m_acertos, m_erros, m_estado; // estado: 0 ocioso,1 jogando,2 vitoria,3 derrota
  logic [34:0] m_matriz, m_tiros;
  logic [3:0]  sb[$]; // expected {acerto,erro,repetido,invalido}

  function automatic int popc(input logic [34:0] v);
    int n = 0;
    for (int i = 0; i < 35; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_matriz = '0; m_tiros = '0; m_acertos = 0; m_erros = m_max; m_estado = 0;
  endtask

  task automatic do_reset(input bit s10);
    sel10 = s10;
    m_max = s10 ? 10 : 3;
    @(negedge clock);
    reset = 1'b0; enable = 1'b0; confirmar = 1'b0; coordColuna = '0; coordLinha = '0;
    @(negedge clock);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic start();
    @(negedge clock);
    enable = 1'b1;
    tick();
    m_estado = 1;
  endtask

  task automatic press(input int col, input int lin, input int hold);
    logic [3:0] ex, got;
    int idx;
    @(negedge clock);
    coordColuna = 3'(col); coordLinha = 3'(lin); confirmar = 1'b1;
    ex = 4'b0000;
    if (m_estado == 1) begin
      if (col >= 5 || lin >= 7) ex = 4'b0001;
      else begin
        idx = col * 7 + lin;
        if (m_tiros[idx]) ex = 4'b0010;
        else if (mapa[idx]) begin
          ex = 4'b1000; m_tiros[idx] = 1'b1; m_matriz[idx] = 1'b1; m_acertos++;
          if (m_acertos == popc(mapa)) m_estado = 2;
        end else begin
          ex = 4'b0100; m_tiros[idx] = 1'b1;
          if (m_erros == 1) begin m_estado = 3; m_matriz = mapa; end
          m_erros--;
        end
      end
    end
    sb.push_back(ex);
    tick();
    got = sb.pop_front();
    checks++;
    if (o_pulsos !== got) begin failures++; $display("FAIL pulse(%0d,%0d) got=%b exp=%b", col, lin, o_pulsos, got); end
    checks++;
    if ({o_matriz, o_tiros} !== {m_matriz, m_tiros}) begin
      failures++; $display("FAIL arrays(%0d,%0d) matriz=%h/%h tiros=%h/%h", col, lin, o_matriz, m_matriz, o_tiros, m_tiros);
    end
    checks++;
    if ({o_acertos, o_erros, o_vit, o_der} !== {6'(m_acertos), 4'(m_erros), m_estado == 2, m_estado == 3}) begin
      failures++; $display("FAIL counters(%0d,%0d) acertos=%0d/%0d erros=%0d/%0d vit=%b der=%b estado=%0d",
                           col, lin, o_acertos, m_acertos, o_erros, m_erros, o_vit, o_der, m_estado);
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      checks++;
      if (o_pulsos !== 4'b0000) begin failures++; $display("FAIL hold_pulse got=%b exp=0000", o_pulsos); end
    end
    @(negedge clock);
    confirmar = 1'b0;
    tick();
    checks++;
    if (o_pulsos !== 4'b0000) begin failures++; $display("FAIL release_pulse got=%b exp=0000", o_pulsos); end
  endtask

  task automatic test_reset();
    mapa = MAPA_TESTE;
    do_reset(0);
    checks++;
    if ({matriz3, tiros3, acertos3, erros3, ac3, er3, rp3, iv3, vit3, der3} !== {35'd0, 35'd0, 6'd0, 2'd3, 6'd0}) begin
      failures++; $display("FAIL reset3 matriz=%h tiros=%h acertos=%0d erros=%0d", matriz3, tiros3, acertos3, erros3);
    end
    checks++;
    if ({acertos10, erros10, vit10, der10} !== {6'd0, 4'd10, 2'b00}) begin
      failures++; $display("FAIL reset10 acertos=%0d erros=%0d exp 0/10", acertos10, erros10);
    end
    start();
  endtask

  task automatic test_hit_hold();
    press(0, 0, 5);
    checks++;
    if (o_acertos !== 6'd1 || o_matriz[0] !== 1'b1 || o_tiros[0] !== 1'b1) begin
      failures++; $display("FAIL first_hit acertos=%0d matriz0=%b tiros0=%b exp 1/1/1", o_acertos, o_matriz[0], o_tiros[0]);
    end
  endtask

  task automatic test_repeat_invalid();
    press(0, 0, 0);
    press(0, 7, 0);
    press(5, 0, 0);
    checks++;
    if (o_acertos !== 6'd1 || o_tiros !== 35'd1) begin
      failures++; $display("FAIL repeat_invalid acertos=%0d tiros=%h exp 1/1", o_acertos, o_tiros);
    end
  endtask

  task automatic test_misses();
    press(2, 3, 0);
    press(3, 0, 0);
    press(3, 1, 0);
    checks++;
    if (o_der !== 1'b1 || o_matriz !== MAPA_TESTE || o_erros !== 4'd0) begin
      failures++; $display("FAIL defeat der=%b matriz=%h erros=%0d exp 1/%h/0", o_der, o_matriz, o_erros, MAPA_TESTE);
    end
    press(4, 4, 0);
  endtask

  task automatic test_win();
    do_reset(1);
    start();
    press(0, 0, 0); press(0, 4, 0); press(0, 5, 0); press(0, 6, 0);
    press(1, 5, 0); press(4, 4, 0); press(4, 5, 0); press(4, 6, 0);
    checks++;
    if (o_vit !== 1'b1 || o_acertos !== 6'd8 || o_matriz !== MAPA_TESTE) begin
      failures++; $display("FAIL win vit=%b acertos=%0d matriz=%h exp 1/8/%h", o_vit, o_acertos, o_matriz, MAPA_TESTE);
    end
    press(2, 2, 0);
  endtask

  task automatic test_enable_and_async_reset();
    do_reset(0);
    start();
    press(0, 0, 0);
    @(negedge clock);
    enable = 1'b0; confirmar = 1'b1; coordColuna = 3'd1; coordLinha = 3'd5;
    tick();
    model_reset();
    checks++;
    if ({o_matriz, o_tiros, o_acertos, o_erros, o_pulsos, o_vit, o_der} !== {35'd0, 35'd0, 6'd0, 4'd3, 4'd0, 2'b00}) begin
      failures++; $display("FAIL enable_clear matriz=%h acertos=%0d erros=%0d pulsos=%b", o_matriz, o_acertos, o_erros, o_pulsos);
    end
    @(negedge clock);
    enable = 1'b1;
    tick();
    checks++;
    if (o_pulsos !== 4'b0000) begin failures++; $display("FAIL idle_press pulsos=%b exp=0000", o_pulsos); end
    @(negedge clock);
    confirmar = 1'b0;
    tick();
    m_estado = 1;
    press(0, 4, 0);
    press(3, 3, 0);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({o_matriz, o_tiros, o_acertos, o_erros} !== {35'd0, 35'd0, 6'd0, 4'd3}) begin
      failures++; $display("FAIL async_reset matriz=%h tiros=%h acertos=%0d erros=%0d", o_matriz, o_tiros, o_acertos, o_erros);
    end
    reset = 1'b1;
  endtask

  task automatic test_empty_map();
    int n;
    mapa = '0;
    do_reset(0);
    @(negedge clock);
    enable = 1'b1;
    n = 0;
    while (n < 2 && o_vit !== 1'b1) begin
      tick();
      n++;
    end
    checks++;
    if (o_vit !== 1'b1 || o_acertos !== 6'd0) begin
      failures++; $display("FAIL empty_map vit=%b acertos=%0d after %0d cycles exp 1/0", o_vit, o_acertos, n);
    end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; confirmar = 1'b0;
    coordColuna = '0; coordLinha = '0; mapa = MAPA_TESTE; sel10 = 1'b0;
    m_max = 3;
    model_reset();
    test_reset();
    test_hit_hold();
    test_repeat_invalid();
    test_misses();
    test_win();
    mapa = MAPA_TESTE;
    test_enable_and_async_reset();
    test_empty_map();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
